axilite_reg_bridge: RTL and testbench
=====================================

Name: axilite_reg_bridge

Overview:
Parametrised AXI4-Lite slave that converts AXI write and read transactions into a simple single-cycle request / acknowledge register-bus protocol.
- Generalises data width and carries byte strobes through to the register bus.
- Accepts AW and W independently, in either order.
- Returns DECERR for out-of-range addresses without issuing a request, and SLVERR on acknowledge timeout.
- Keeps saturating timeout statistics.
- Sits between the AXI interconnect and user register files.

Parameters:
AXI_ADDRESS_WIDTH, 16, AXI byte-address width.
AXI_DATA_WIDTH, 32, data width; legal values 32 or 64. Define SB = log2(AXI_DATA_WIDTH/8).
VALID_ADDR_RANGE, 16'h000F, highest legal byte address; any address above it returns DECERR.
REQ_TIMEOUT, 32, maximum cycles spent waiting for ack; must be ≥2.

Ports:
AXI_ACLK  in  1  single clock; everything is on the rising edge.
AXI_RESETN  in  1  synchronous, active-low reset.
AXI_AWVALID/AXI_AWREADY  in/out  1  write-address handshake.
AXI_AWADDR  in  AXI_ADDRESS_WIDTH  write byte address.
AXI_WVALID/AXI_WREADY  in/out  1  write-data handshake.
AXI_WDATA  in  AXI_DATA_WIDTH  write data.
AXI_WSTRB  in  AXI_DATA_WIDTH/8  byte strobes.
AXI_BVALID  out  1  write response valid.
AXI_BRESP  out  2  write response.
AXI_BREADY  in  1  write response ready.
AXI_ARVALID/AXI_ARREADY  in/out  1  read-address handshake.
AXI_ARADDR  in  AXI_ADDRESS_WIDTH  read byte address.
AXI_RVALID  out  1  read data valid.
AXI_RRESP  out  2  read response.
AXI_RDATA  out  AXI_DATA_WIDTH  read data.
AXI_RREADY  in  1  read data ready.
axi_wreq  out  1  one-cycle write request pulse.
axi_waddr  out  AXI_ADDRESS_WIDTH-SB  word address, AWADDR[AW-1:SB].
axi_wdata  out  AXI_DATA_WIDTH  write data.
axi_wstrb  out  AXI_DATA_WIDTH/8  byte enables.
axi_wack  in  1  write acknowledge.
axi_rreq  out  1  one-cycle read request pulse.
axi_raddr  out  AXI_ADDRESS_WIDTH-SB  read word address.
axi_rdata  in  AXI_DATA_WIDTH  read data, valid when axi_rack=1.
axi_rack  in  1  read acknowledge.
wr_timeout_cnt  out  16  saturating count of write timeouts.
rd_timeout_cnt  out  16  saturating count of read timeouts.

Behaviour:
Reset:
- One clock; synchronous active-low reset on AXI_RESETN, sampled at the AXI_ACLK rising edge.
- All outputs are registered. Reset drives every output to 0: READYs, VALIDs, RESPs, RDATA, req, addr, data, strb and both counters.
- At the first edge with reset high, AWREADY, WREADY and ARREADY rise to 1.

Write FSM, states W_IDLE → W_REQ → W_WAIT → W_RESP:
- W_IDLE: AWREADY=1 until AW is captured, WREADY=1 until W is captured; each drops the cycle after its own handshake.
  - AW and W may arrive in the same cycle or either first.
  - Once both are captured: if AWADDR > VALID_ADDR_RANGE, go to W_RESP with DECERR and issue no request; otherwise go to W_REQ.
- W_REQ: axi_wreq=1 for exactly one cycle, with axi_waddr/wdata/wstrb stable. Clear the counter, then go to W_WAIT.
- W_WAIT:
  - axi_wack=1 → W_RESP with OKAY.
  - Otherwise the counter increments; when it equals REQ_TIMEOUT-1 with no ack → W_RESP with SLVERR, and wr_timeout_cnt increments, saturating at 16'hFFFF.
  - If ack and timeout coincide, ack wins.
- W_RESP: BVALID=1, BRESP held, until BVALID&&BREADY. Then go to W_IDLE; AWREADY/WREADY re-assert the next cycle.
- axi_wack outside W_WAIT is ignored.
- axi_waddr/wdata/wstrb hold their last values between transactions.

Read FSM, states R_IDLE → R_REQ → R_WAIT → R_RESP:
- R_IDLE: ARREADY=1, drops after the handshake.
  - Out-of-range address → R_RESP with RDATA=0, DECERR.
  - Otherwise → R_REQ.
- R_REQ: axi_rreq=1 for one cycle, axi_raddr=ARADDR[AW-1:SB].
- R_WAIT:
  - axi_rack=1 → RDATA<=axi_rdata, OKAY.
  - Timeout as for writes → RDATA=0, SLVERR, rd_timeout_cnt increments (saturating).
- R_RESP: RVALID=1 with RDATA/RRESP stable until RVALID&&RREADY. Then go to R_IDLE.

Latency, no backpressure:
- Handshake at edge 0 → req high in cycle 1.
- Ack in cycle k → VALID high in cycle k+1.
- Minimum latency from handshake to VALID is 3 cycles.

Concurrency and error rules:
- The write and read paths are fully independent; wreq and rreq may pulse in the same cycle.
- Only one outstanding transaction per direction.
- The address low bits [SB-1:0] are ignored for decode but included in the range check.
- EXOKAY is never returned.

Reset mid-operation: the FSMs return to idle, VALIDs and req drop to 0, counters clear, and a late ack after reset is ignored.

Test Plan:
1. AW+W in the same cycle, addr 0x8, data 0xDEADBEEF, strb 0xF, ack 2 cycles after wreq → wreq pulse with waddr=2, wdata=0xDEADBEEF, wstrb=0xF; BVALID with OKAY; exactly one wreq.
2. W presented 3 cycles before AW (addr 0x4, strb 0x3) → WREADY drops after the W handshake, wreq issued only after the AW handshake, wstrb=0x3, OKAY.
3. Write addr 0x20 (>0x0F) → no wreq ever; BRESP=DECERR. Read addr 0x40 → no rreq; RRESP=DECERR, RDATA=0.
4. Read addr 0xC, no ack, REQ_TIMEOUT=32 → RVALID 32 cycles after the R_WAIT entry; SLVERR, RDATA=0, rd_timeout_cnt=1. A late rack is ignored.
5. Read addr 0x0 with rack=1 and rdata=0x12345678, RREADY held low 5 cycles → RVALID and RDATA stable for all 6 cycles, then RVALID drops the cycle after the RREADY handshake. A concurrent write issues wreq in the same cycle as rreq.
6. Reset asserted in W_WAIT with BREADY low → after reset all outputs are 0, READYs re-assert the next cycle, and an ack arriving then produces no BVALID.

Source files
------------

// File: rtl/axilite_reg_bridge.sv
// AXI4-Lite slave bridged onto a single-cycle req/ack register bus; all outputs registered.
// Handshake -> req 1 cycle, ack -> VALID 1 cycle (3 min); one outstanding per direction, READY low while busy.
module axilite_reg_bridge #(
    parameter int AXI_ADDRESS_WIDTH = 16,
    parameter int AXI_DATA_WIDTH = 32,
    parameter logic [AXI_ADDRESS_WIDTH-1:0] VALID_ADDR_RANGE = 16'h000F,
    parameter int REQ_TIMEOUT = 32
) (
    input  logic                                         AXI_ACLK,
    input  logic                                         AXI_RESETN,
    input  logic                                         AXI_AWVALID,
    output logic                                         AXI_AWREADY,
    input  logic [AXI_ADDRESS_WIDTH-1:0]                 AXI_AWADDR,
    input  logic                                         AXI_WVALID,
    output logic                                         AXI_WREADY,
    input  logic [AXI_DATA_WIDTH-1:0]                    AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]                  AXI_WSTRB,
    output logic                                         AXI_BVALID,
    output logic [1:0]                                   AXI_BRESP,
    input  logic                                         AXI_BREADY,
    input  logic                                         AXI_ARVALID,
    output logic                                         AXI_ARREADY,
    input  logic [AXI_ADDRESS_WIDTH-1:0]                 AXI_ARADDR,
    output logic                                         AXI_RVALID,
    output logic [1:0]                                   AXI_RRESP,
    output logic [AXI_DATA_WIDTH-1:0]                    AXI_RDATA,
    input  logic                                         AXI_RREADY,
    output logic                                         axi_wreq,
    output logic [AXI_ADDRESS_WIDTH-$clog2(AXI_DATA_WIDTH/8)-1:0] axi_waddr,
    output logic [AXI_DATA_WIDTH-1:0]                    axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]                  axi_wstrb,
    input  logic                                         axi_wack,
    output logic                                         axi_rreq,
    output logic [AXI_ADDRESS_WIDTH-$clog2(AXI_DATA_WIDTH/8)-1:0] axi_raddr,
    input  logic [AXI_DATA_WIDTH-1:0]                    axi_rdata,
    input  logic                                         axi_rack,
    output logic [15:0]                                  wr_timeout_cnt,
    output logic [15:0]                                  rd_timeout_cnt
);
    localparam int AW = AXI_ADDRESS_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;
    localparam int BW = AXI_DATA_WIDTH / 8;
    localparam int SB = $clog2(BW);
    localparam int CW = (REQ_TIMEOUT > 2) ? $clog2(REQ_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(REQ_TIMEOUT - 1);
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} r_state_t;

    // Write side: addr/data/strb hold the captured beat; waddr/wdata/wstrb are the bus copies.
    typedef struct packed {
        w_state_t         st;
        logic             aw_done;
        logic             w_done;
        logic [AW-1:0]    addr;
        logic [DW-1:0]    data;
        logic [BW-1:0]    strb;
        logic             awready;
        logic             wready;
        logic             bvalid;
        logic [1:0]       bresp;
        logic             req;
        logic [AW-SB-1:0] waddr;
        logic [DW-1:0]    wdata;
        logic [BW-1:0]    wstrb;
        logic [CW-1:0]    cnt;
        logic [15:0]      to_cnt;
    } wr_regs_t;

    typedef struct packed {
        r_state_t         st;
        logic             arready;
        logic             rvalid;
        logic [1:0]       rresp;
        logic [DW-1:0]    rdata;
        logic             req;
        logic [AW-SB-1:0] raddr;
        logic [CW-1:0]    cnt;
        logic [15:0]      to_cnt;
    } rd_regs_t;

    wr_regs_t wq, wd;
    rd_regs_t rq, rd;
    logic     aw_hs, w_hs, ar_hs;

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_RESETN) begin
            wq <= '0;
            rq <= '0;
        end else begin
            wq <= wd;
            rq <= rd;
        end
    end

    always_comb begin
        aw_hs  = AXI_AWVALID && wq.awready;
        w_hs   = AXI_WVALID && wq.wready;
        wd     = wq;
        wd.req = 1'b0;
        case (wq.st)
            W_IDLE: begin
                if (aw_hs) begin
                    wd.addr    = AXI_AWADDR;
                    wd.aw_done = 1'b1;
                end
                if (w_hs) begin
                    wd.data   = AXI_WDATA;
                    wd.strb   = AXI_WSTRB;
                    wd.w_done = 1'b1;
                end
                wd.awready = !wd.aw_done;
                wd.wready  = !wd.w_done;
                if (wd.aw_done && wd.w_done) begin
                    wd.aw_done = 1'b0;
                    wd.w_done  = 1'b0;
                    // Range check uses the full byte address, low bits included.
                    if (wd.addr > VALID_ADDR_RANGE) begin
                        wd.st     = W_RESP;
                        wd.bvalid = 1'b1;
                        wd.bresp  = DECERR;
                    end else begin
                        wd.st    = W_REQ;
                        wd.req   = 1'b1;
                        wd.waddr = wd.addr[AW-1:SB];
                        wd.wdata = wd.data;
                        wd.wstrb = wd.strb;
                    end
                end
            end
            W_REQ: begin
                wd.st  = W_WAIT;
                wd.cnt = '0;
            end
            W_WAIT: begin
                if (axi_wack) begin
                    wd.st     = W_RESP;
                    wd.bvalid = 1'b1;
                    wd.bresp  = OKAY;
                end else if (wq.cnt == TO_LAST) begin
                    wd.st     = W_RESP;
                    wd.bvalid = 1'b1;
                    wd.bresp  = SLVERR;
                    if (wq.to_cnt != 16'hFFFF) wd.to_cnt = wq.to_cnt + 16'd1;
                end else begin
                    wd.cnt = wq.cnt + 1'b1;
                end
            end
            W_RESP: begin
                if (AXI_BREADY) begin
                    wd.st      = W_IDLE;
                    wd.bvalid  = 1'b0;
                    wd.awready = 1'b1;
                    wd.wready  = 1'b1;
                end
            end
            default: wd.st = W_IDLE;
        endcase
    end

    always_comb begin
        ar_hs  = AXI_ARVALID && rq.arready;
        rd     = rq;
        rd.req = 1'b0;
        case (rq.st)
            R_IDLE: begin
                rd.arready = 1'b1;
                if (ar_hs) begin
                    rd.arready = 1'b0;
                    if (AXI_ARADDR > VALID_ADDR_RANGE) begin
                        rd.st     = R_RESP;
                        rd.rvalid = 1'b1;
                        rd.rresp  = DECERR;
                        rd.rdata  = '0;
                    end else begin
                        rd.st    = R_REQ;
                        rd.req   = 1'b1;
                        rd.raddr = AXI_ARADDR[AW-1:SB];
                    end
                end
            end
            R_REQ: begin
                rd.st  = R_WAIT;
                rd.cnt = '0;
            end
            R_WAIT: begin
                if (axi_rack) begin
                    rd.st     = R_RESP;
                    rd.rvalid = 1'b1;
                    rd.rresp  = OKAY;
                    rd.rdata  = axi_rdata;
                end else if (rq.cnt == TO_LAST) begin
                    rd.st     = R_RESP;
                    rd.rvalid = 1'b1;
                    rd.rresp  = SLVERR;
                    rd.rdata  = '0;
                    if (rq.to_cnt != 16'hFFFF) rd.to_cnt = rq.to_cnt + 16'd1;
                end else begin
                    rd.cnt = rq.cnt + 1'b1;
                end
            end
            R_RESP: begin
                if (AXI_RREADY) begin
                    rd.st      = R_IDLE;
                    rd.rvalid  = 1'b0;
                    rd.arready = 1'b1;
                end
            end
            default: rd.st = R_IDLE;
        endcase
    end

    assign AXI_AWREADY    = wq.awready;
    assign AXI_WREADY     = wq.wready;
    assign AXI_BVALID     = wq.bvalid;
    assign AXI_BRESP      = wq.bresp;
    assign axi_wreq       = wq.req;
    assign axi_waddr      = wq.waddr;
    assign axi_wdata      = wq.wdata;
    assign axi_wstrb      = wq.wstrb;
    assign wr_timeout_cnt = wq.to_cnt;
    assign AXI_ARREADY    = rq.arready;
    assign AXI_RVALID     = rq.rvalid;
    assign AXI_RRESP      = rq.rresp;
    assign AXI_RDATA      = rq.rdata;
    assign axi_rreq       = rq.req;
    assign axi_raddr      = rq.raddr;
    assign rd_timeout_cnt = rq.to_cnt;
endmodule

// File: tb/tb_axilite_reg_bridge.sv
// Directed bench for axilite_reg_bridge: vector table plus hand-written multi-cycle sequences.
module tb_axilite_reg_bridge;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        AXI_RESETN;
    logic        AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY;
    logic [15:0] AXI_AWADDR, AXI_ARADDR;
    logic [31:0] AXI_WDATA, AXI_RDATA;
    logic [3:0]  AXI_WSTRB;
    logic        AXI_BVALID, AXI_BREADY, AXI_ARVALID, AXI_ARREADY, AXI_RVALID, AXI_RREADY;
    logic [1:0]  AXI_BRESP, AXI_RRESP;
    logic        axi_wreq, axi_wack, axi_rreq, axi_rack;
    logic [13:0] axi_waddr, axi_raddr;
    logic [31:0] axi_wdata, axi_rdata;
    logic [3:0]  axi_wstrb;
    logic [15:0] wr_timeout_cnt, rd_timeout_cnt;

    axilite_reg_bridge dut (
        .AXI_ACLK(clk), .AXI_RESETN(AXI_RESETN),
        .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY), .AXI_AWADDR(AXI_AWADDR),
        .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY), .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB),
        .AXI_BVALID(AXI_BVALID), .AXI_BRESP(AXI_BRESP), .AXI_BREADY(AXI_BREADY),
        .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY), .AXI_ARADDR(AXI_ARADDR),
        .AXI_RVALID(AXI_RVALID), .AXI_RRESP(AXI_RRESP), .AXI_RDATA(AXI_RDATA), .AXI_RREADY(AXI_RREADY),
        .axi_wreq(axi_wreq), .axi_waddr(axi_waddr), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wack(axi_wack), .axi_rreq(axi_rreq), .axi_raddr(axi_raddr), .axi_rdata(axi_rdata),
        .axi_rack(axi_rack), .wr_timeout_cnt(wr_timeout_cnt), .rd_timeout_cnt(rd_timeout_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Request monitor: counts pulses and keeps the bus values seen with each pulse.
    int          wreq_n = 0;
    int          rreq_n = 0;
    logic [13:0] cap_waddr, cap_raddr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;
    always @(negedge clk) begin
        if (axi_wreq === 1'b1) begin
            wreq_n++;
            cap_waddr = axi_waddr;
            cap_wdata = axi_wdata;
            cap_wstrb = axi_wstrb;
        end
        if (axi_rreq === 1'b1) begin
            rreq_n++;
            cap_raddr = axi_raddr;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_awready"}, 64'(AXI_AWREADY), 64'd0);
        chk({tag, "_wready"},  64'(AXI_WREADY),  64'd0);
        chk({tag, "_arready"}, 64'(AXI_ARREADY), 64'd0);
        chk({tag, "_bvalid"},  64'(AXI_BVALID),  64'd0);
        chk({tag, "_bresp"},   64'(AXI_BRESP),   64'd0);
        chk({tag, "_rvalid"},  64'(AXI_RVALID),  64'd0);
        chk({tag, "_rresp"},   64'(AXI_RRESP),   64'd0);
        chk({tag, "_rdata"},   64'(AXI_RDATA),   64'd0);
        chk({tag, "_wreq"},    64'(axi_wreq),    64'd0);
        chk({tag, "_waddr"},   64'(axi_waddr),   64'd0);
        chk({tag, "_wdata"},   64'(axi_wdata),   64'd0);
        chk({tag, "_wstrb"},   64'(axi_wstrb),   64'd0);
        chk({tag, "_rreq"},    64'(axi_rreq),    64'd0);
        chk({tag, "_raddr"},   64'(axi_raddr),   64'd0);
        chk({tag, "_wto"},     64'(wr_timeout_cnt), 64'd0);
        chk({tag, "_rto"},     64'(rd_timeout_cnt), 64'd0);
    endtask

    // dly < 0: never ack. Otherwise ack is driven dly negedges after wreq is first seen.
    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int dly, output logic [1:0] resp);
        int n;
        bit awp, wp, awg, wg;
        @(negedge clk);
        AXI_AWVALID = 1'b1; AXI_AWADDR = a;
        AXI_WVALID = 1'b1; AXI_WDATA = d; AXI_WSTRB = s;
        awp = 1'b1; wp = 1'b1; n = 0;
        while ((awp || wp) && n < 20) begin
            awg = awp && (AXI_AWREADY === 1'b1);
            wg  = wp && (AXI_WREADY === 1'b1);
            @(negedge clk);
            n++;
            if (awg) begin awp = 1'b0; AXI_AWVALID = 1'b0; end
            if (wg) begin wp = 1'b0; AXI_WVALID = 1'b0; end
        end
        if (awp || wp) chk("w_handshake_bound", 64'd0, 64'd1);
        if (dly >= 0) begin
            n = 0;
            while (axi_wreq !== 1'b1 && n < 5) begin @(negedge clk); n++; end
            if (axi_wreq === 1'b1) begin
                repeat (dly) @(negedge clk);
                axi_wack = 1'b1;
                @(negedge clk);
                axi_wack = 1'b0;
            end
        end
        n = 0;
        while (AXI_BVALID !== 1'b1 && n < 80) begin @(negedge clk); n++; end
        if (AXI_BVALID !== 1'b1) chk("bvalid_bound", 64'd0, 64'd1);
        resp = AXI_BRESP;
        AXI_BREADY = 1'b1;
        @(negedge clk);
        AXI_BREADY = 1'b0;
        chk("bvalid_drop", 64'(AXI_BVALID), 64'd0);
    endtask

    task automatic axi_read(input logic [15:0] a, input logic [31:0] d, input int dly,
                            output logic [1:0] resp, output logic [31:0] dat);
        int n;
        @(negedge clk);
        AXI_ARVALID = 1'b1; AXI_ARADDR = a;
        n = 0;
        while (AXI_ARREADY !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (AXI_ARREADY !== 1'b1) chk("ar_handshake_bound", 64'd0, 64'd1);
        @(negedge clk);
        AXI_ARVALID = 1'b0;
        if (dly >= 0) begin
            n = 0;
            while (axi_rreq !== 1'b1 && n < 5) begin @(negedge clk); n++; end
            if (axi_rreq === 1'b1) begin
                repeat (dly) @(negedge clk);
                axi_rack = 1'b1; axi_rdata = d;
                @(negedge clk);
                axi_rack = 1'b0; axi_rdata = 32'h0;
            end
        end
        n = 0;
        while (AXI_RVALID !== 1'b1 && n < 80) begin @(negedge clk); n++; end
        if (AXI_RVALID !== 1'b1) chk("rvalid_bound", 64'd0, 64'd1);
        resp = AXI_RRESP;
        dat  = AXI_RDATA;
        AXI_RREADY = 1'b1;
        @(negedge clk);
        AXI_RREADY = 1'b0;
        chk("rvalid_drop", 64'(AXI_RVALID), 64'd0);
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          dly;
        logic [1:0]  exp_resp;
        int          exp_nreq;
        logic [13:0] exp_qaddr;
        logic [31:0] exp_dat;
        int          exp_wto;
        int          exp_rto;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    initial begin
        logic [1:0]  resp;
        logic [31:0] rdat;
        int          w0, r0, n;
        vec_t        v;

        // ack delay 32 lands on the last counter value (ack wins); 33 arrives after timeout.
        vecs[0]  = '{1'b1, 16'h0008, 32'hDEADBEEF, 4'hF, 2,  2'b00, 1, 14'd2, 32'hDEADBEEF, 0, 0};
        vecs[1]  = '{1'b1, 16'h000C, 32'h01020304, 4'h5, 1,  2'b00, 1, 14'd3, 32'h01020304, 0, 0};
        vecs[2]  = '{1'b1, 16'h0020, 32'hAAAA5555, 4'hF, -1, 2'b11, 0, 14'd0, 32'h0,        0, 0};
        vecs[3]  = '{1'b1, 16'h0010, 32'h5555AAAA, 4'hF, -1, 2'b11, 0, 14'd0, 32'h0,        0, 0};
        vecs[4]  = '{1'b1, 16'h000F, 32'h00FF00FF, 4'h8, 4,  2'b00, 1, 14'd3, 32'h00FF00FF, 0, 0};
        vecs[5]  = '{1'b0, 16'h0000, 32'h12345678, 4'h0, 1,  2'b00, 1, 14'd0, 32'h12345678, 0, 0};
        vecs[6]  = '{1'b0, 16'h0040, 32'hFFFFFFFF, 4'h0, -1, 2'b11, 0, 14'd0, 32'h0,        0, 0};
        vecs[7]  = '{1'b0, 16'h000E, 32'hA5A50F0F, 4'h0, 3,  2'b00, 1, 14'd3, 32'hA5A50F0F, 0, 0};
        vecs[8]  = '{1'b0, 16'h0010, 32'h0,        4'h0, -1, 2'b11, 0, 14'd0, 32'h0,        0, 0};
        vecs[9]  = '{1'b1, 16'h0004, 32'hCAFEF00D, 4'h3, -1, 2'b10, 1, 14'd1, 32'hCAFEF00D, 1, 0};
        vecs[10] = '{1'b1, 16'h0008, 32'h11112222, 4'hF, 32, 2'b00, 1, 14'd2, 32'h11112222, 1, 0};
        vecs[11] = '{1'b1, 16'h0000, 32'h33334444, 4'h1, 33, 2'b10, 1, 14'd0, 32'h33334444, 2, 0};
        vecs[12] = '{1'b0, 16'h0004, 32'h55556666, 4'h0, 32, 2'b00, 1, 14'd1, 32'h55556666, 2, 0};
        vecs[13] = '{1'b0, 16'h0008, 32'h77776666, 4'h0, 33, 2'b10, 1, 14'd2, 32'h0,        2, 1};

        AXI_RESETN = 1'b0;
        AXI_AWVALID = 1'b0; AXI_AWADDR = '0; AXI_WVALID = 1'b0; AXI_WDATA = '0; AXI_WSTRB = '0;
        AXI_BREADY = 1'b0; AXI_ARVALID = 1'b0; AXI_ARADDR = '0; AXI_RREADY = 1'b0;
        axi_wack = 1'b0; axi_rack = 1'b0; axi_rdata = '0;

        repeat (2) @(negedge clk);
        check_all_zero("rst");
        AXI_RESETN = 1'b1;
        @(negedge clk);
        chk("rst_rel_awready", 64'(AXI_AWREADY), 64'd1);
        chk("rst_rel_wready",  64'(AXI_WREADY),  64'd1);
        chk("rst_rel_arready", 64'(AXI_ARREADY), 64'd1);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            w0 = wreq_n;
            r0 = rreq_n;
            if (v.wr) begin
                axi_write(v.addr, v.data, v.strb, v.dly, resp);
                chk($sformatf("v%0d_bresp", i), 64'(resp), 64'(v.exp_resp));
                chk($sformatf("v%0d_nwreq", i), 64'(wreq_n - w0), 64'(v.exp_nreq));
                if (v.exp_nreq > 0) begin
                    chk($sformatf("v%0d_waddr", i), 64'(cap_waddr), 64'(v.exp_qaddr));
                    chk($sformatf("v%0d_wdata", i), 64'(cap_wdata), 64'(v.exp_dat));
                    chk($sformatf("v%0d_wstrb", i), 64'(cap_wstrb), 64'(v.strb));
                end
            end else begin
                axi_read(v.addr, v.data, v.dly, resp, rdat);
                chk($sformatf("v%0d_rresp", i), 64'(resp), 64'(v.exp_resp));
                chk($sformatf("v%0d_nrreq", i), 64'(rreq_n - r0), 64'(v.exp_nreq));
                if (v.exp_nreq > 0)
                    chk($sformatf("v%0d_raddr", i), 64'(cap_raddr), 64'(v.exp_qaddr));
                chk($sformatf("v%0d_rdata", i), 64'(rdat), 64'(v.exp_dat));
            end
            chk($sformatf("v%0d_wto", i), 64'(wr_timeout_cnt), 64'(v.exp_wto));
            chk($sformatf("v%0d_rto", i), 64'(rd_timeout_cnt), 64'(v.exp_rto));
        end

        // W arrives three cycles ahead of AW.
        @(negedge clk);
        w0 = wreq_n;
        chk("wfirst_wready_pre", 64'(AXI_WREADY), 64'd1);
        AXI_WVALID = 1'b1; AXI_WDATA = 32'h0BADF00D; AXI_WSTRB = 4'h3;
        @(negedge clk);
        AXI_WVALID = 1'b0;
        chk("wfirst_wready_drop", 64'(AXI_WREADY), 64'd0);
        chk("wfirst_awready_hold", 64'(AXI_AWREADY), 64'd1);
        chk("wfirst_noreq_0", 64'(axi_wreq), 64'd0);
        @(negedge clk);
        chk("wfirst_noreq_1", 64'(axi_wreq), 64'd0);
        @(negedge clk);
        chk("wfirst_noreq_2", 64'(axi_wreq), 64'd0);
        AXI_AWVALID = 1'b1; AXI_AWADDR = 16'h0004;
        @(negedge clk);
        AXI_AWVALID = 1'b0;
        chk("wfirst_wreq", 64'(axi_wreq), 64'd1);
        chk("wfirst_waddr", 64'(axi_waddr), 64'd1);
        chk("wfirst_wstrb", 64'(axi_wstrb), 64'h3);
        chk("wfirst_wdata", 64'(axi_wdata), 64'h0BADF00D);
        @(negedge clk);
        axi_wack = 1'b1;
        @(negedge clk);
        axi_wack = 1'b0;
        chk("wfirst_bvalid", 64'(AXI_BVALID), 64'd1);
        chk("wfirst_bresp", 64'(AXI_BRESP), 64'd0);
        AXI_BREADY = 1'b1;
        @(negedge clk);
        AXI_BREADY = 1'b0;
        chk("wfirst_nwreq", 64'(wreq_n - w0), 64'd1);

        // Concurrent write and read; read response stalled 5 cycles by RREADY.
        @(negedge clk);
        AXI_AWVALID = 1'b1; AXI_AWADDR = 16'h0004; AXI_WVALID = 1'b1;
        AXI_WDATA = 32'h77778888; AXI_WSTRB = 4'hF;
        AXI_ARVALID = 1'b1; AXI_ARADDR = 16'h0000;
        @(negedge clk);
        AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0; AXI_ARVALID = 1'b0;
        chk("conc_wreq", 64'(axi_wreq), 64'd1);
        chk("conc_rreq", 64'(axi_rreq), 64'd1);
        @(negedge clk);
        axi_wack = 1'b1; axi_rack = 1'b1; axi_rdata = 32'h12345678;
        @(negedge clk);
        axi_wack = 1'b0; axi_rack = 1'b0; axi_rdata = 32'h0;
        chk("conc_bvalid", 64'(AXI_BVALID), 64'd1);
        chk("conc_bresp", 64'(AXI_BRESP), 64'd0);
        chk("conc_rresp", 64'(AXI_RRESP), 64'd0);
        AXI_BREADY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("stall%0d_rvalid", i), 64'(AXI_RVALID), 64'd1);
            chk($sformatf("stall%0d_rdata", i), 64'(AXI_RDATA), 64'h12345678);
            if (i == 5) AXI_RREADY = 1'b1;
            @(negedge clk);
            if (i == 0) begin
                AXI_BREADY = 1'b0;
                chk("conc_bvalid_drop", 64'(AXI_BVALID), 64'd0);
            end
        end
        AXI_RREADY = 1'b0;
        chk("stall_rvalid_drop", 64'(AXI_RVALID), 64'd0);

        // Read timeout: RVALID 33 negedges after rreq is seen, then a late rack is ignored.
        @(negedge clk);
        AXI_ARVALID = 1'b1; AXI_ARADDR = 16'h000C;
        @(negedge clk);
        AXI_ARVALID = 1'b0;
        chk("to_rreq", 64'(axi_rreq), 64'd1);
        n = 0;
        while (AXI_RVALID !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        chk("to_latency", 64'(n), 64'd33);
        chk("to_rresp", 64'(AXI_RRESP), 64'h2);
        chk("to_rdata", 64'(AXI_RDATA), 64'd0);
        chk("to_rto", 64'(rd_timeout_cnt), 64'd2);
        AXI_RREADY = 1'b1;
        @(negedge clk);
        AXI_RREADY = 1'b0;
        axi_rack = 1'b1; axi_rdata = 32'hFEEDFACE;
        @(negedge clk);
        axi_rack = 1'b0; axi_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("late_rack_rvalid", 64'(AXI_RVALID), 64'd0);
        chk("late_rack_rto", 64'(rd_timeout_cnt), 64'd2);

        // Reset while waiting for write ack, then an ack arriving after reset.
        @(negedge clk);
        w0 = wreq_n;
        AXI_AWVALID = 1'b1; AXI_AWADDR = 16'h0008; AXI_WVALID = 1'b1;
        AXI_WDATA = 32'h99990000; AXI_WSTRB = 4'hC;
        @(negedge clk);
        AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0;
        chk("mid_wreq", 64'(axi_wreq), 64'd1);
        repeat (3) @(negedge clk);
        AXI_RESETN = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        AXI_RESETN = 1'b1;
        @(negedge clk);
        chk("midrst_awready", 64'(AXI_AWREADY), 64'd1);
        chk("midrst_wready",  64'(AXI_WREADY),  64'd1);
        chk("midrst_arready", 64'(AXI_ARREADY), 64'd1);
        axi_wack = 1'b1;
        @(negedge clk);
        axi_wack = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_no_bvalid", 64'(AXI_BVALID), 64'd0);
        chk("midrst_nwreq", 64'(wreq_n - w0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
